// File: rtl/tri_host_if.sv
// ---------------------------------------------------------------------------
// tri_host_if
// Bundles every signal of the triangle host controller except clock and
// reset. It covers the command handshake, the renderer link and the
// frame-buffer read port.
//   master : the host controller (tri_host_ctrl)
//   slave  : the command source, the renderer and the frame-buffer reader
// Signals:
//   cmd_valid/cmd_ready/cmd_vtx  command handshake, {x0,y0,x1,y1,x2,y2}
//   nt/xi/yi                     new-triangle strobe and vertex to renderer
//   busy/po/xo/yo                renderer status and pixel stream
//   fb_rd_row/fb_rd_data         bitmap row select and row contents
//   pix_cnt/done/timeout         distinct pixel count, completion, watchdog
// ---------------------------------------------------------------------------
interface tri_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [17:0] cmd_vtx;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        busy;
    logic        po;
    logic [2:0]  xo;
    logic [2:0]  yo;
    logic [2:0]  fb_rd_row;
    logic [7:0]  fb_rd_data;
    logic [6:0]  pix_cnt;
    logic        done;
    logic        timeout;

    modport master (
        input  cmd_valid, cmd_vtx, busy, po, xo, yo, fb_rd_row,
        output cmd_ready, nt, xi, yi, fb_rd_data, pix_cnt, done, timeout
    );

    modport slave (
        output cmd_valid, cmd_vtx, busy, po, xo, yo, fb_rd_row,
        input  cmd_ready, nt, xi, yi, fb_rd_data, pix_cnt, done, timeout
    );
endinterface

// File: rtl/tri_host_ctrl.sv
// ---------------------------------------------------------------------------
// tri_host_ctrl
// Host-side driver for the right-angled-triangle renderer. It accepts one
// triangle command and sends its three vertices on nt/xi/yi. It then
// collects the renderer pixel stream into an 8x8 bitmap, counts the
// distinct pixels and pulses done when the triangle is finished.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    tri_host_if.master (command, renderer, frame-buffer, status)
// Parameters:
//   TIMEOUT_CYCLES  renderer-busy watchdog limit
// Configuration macro:
//   HOST_TIMEOUT_EN  enables the watchdog. When it is undefined, timeout
//                    is tied low and the controller waits indefinitely.
// ---------------------------------------------------------------------------
module tri_host_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    tri_host_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE, SEND0, SEND1, SEND2, WAIT_BUSY, COLLECT, DRAIN, DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Only vertices 1 and 2 are stored. Vertex 0 goes straight onto xi/yi
    // at accept.
    logic [11:0] vtx_q;
    logic        nt_q;
    logic [2:0]  xi_q;
    logic [2:0]  yi_q;

    // Bitmap bit index is {y, x}, so each row is one contiguous byte.
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt_q;
    logic [5:0]  pix_idx;

    logic        accept;
    logic        capture;
    logic        timed_out;
    logic        cmd_ready_c;
    logic        done_c;

    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign capture = ((state == COLLECT) || (state == DRAIN)) && bus.po;
    assign pix_idx = {bus.yo, bus.xo};

`ifdef HOST_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] wd_cnt;
    logic          timeout_q;

    // The watchdog fires only while still waiting. In that cycle the normal
    // exit condition is absent: busy has not risen in WAIT_BUSY, or it has
    // not fallen in COLLECT.
    assign timed_out = (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) &&
                       (((state == WAIT_BUSY) && !bus.busy) ||
                        ((state == COLLECT) && bus.busy));

    // Watchdog counter. It restarts on every state change, so WAIT_BUSY and
    // COLLECT each get a full budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if ((state == WAIT_BUSY) || (state == COLLECT)) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end

    // Sticky timeout flag. It is cleared when the next command is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timed_out          = 1'b0;
    assign bus.timeout        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded outputs.
    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = SEND0;
                end
            end
            SEND0:     state_nxt = SEND1;
            SEND1:     state_nxt = SEND2;
            SEND2:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.busy) begin
                    state_nxt = COLLECT;
                end else if (timed_out) begin
                    state_nxt = DONE;
                end
            end
            COLLECT: begin
                if (!bus.busy) begin
                    state_nxt = DRAIN;
                end else if (timed_out) begin
                    state_nxt = DONE;
                end
            end
            DRAIN:     state_nxt = DONE;
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Vertex sequencing. Each vertex is registered one cycle ahead, so the
    // SENDn state presents vertex n. xi/yi keep vertex 2 until the next
    // accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vtx_q <= '0;
            nt_q  <= 1'b0;
            xi_q  <= '0;
            yi_q  <= '0;
        end else begin
            nt_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        vtx_q <= bus.cmd_vtx[11:0];
                        nt_q  <= 1'b1;
                        xi_q  <= bus.cmd_vtx[17:15];
                        yi_q  <= bus.cmd_vtx[14:12];
                    end
                end
                SEND0: begin
                    xi_q <= vtx_q[11:9];
                    yi_q <= vtx_q[8:6];
                end
                SEND1: begin
                    xi_q <= vtx_q[5:3];
                    yi_q <= vtx_q[2:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Frame buffer and distinct-pixel counter. The old bit value decides
    // whether a pixel is new, so repeated coordinates count only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitmap    <= '0;
            pix_cnt_q <= '0;
        end else if (accept) begin
            bitmap    <= '0;
            pix_cnt_q <= '0;
        end else if (capture) begin
            bitmap[pix_idx] <= 1'b1;
            if (!bitmap[pix_idx]) begin
                pix_cnt_q <= pix_cnt_q + 7'd1;
            end
        end
    end

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.done       = done_c;
    assign bus.nt         = nt_q;
    assign bus.xi         = xi_q;
    assign bus.yi         = yi_q;
    assign bus.pix_cnt    = pix_cnt_q;
    assign bus.fb_rd_data = bitmap[{bus.fb_rd_row, 3'b000} +: 8];

endmodule
